// File: rtl/prefetch_pkg.sv
// Shared definitions for the indirect A[B[i]] prefetch engine: run states and
// index-word geometry.
package prefetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } pf_state_e;

    localparam int IDX_BYTES     = 4;
    localparam int IDX_SHIFT     = 2;
    localparam int DEFAULT_DEPTH = 4;

endpackage

// File: rtl/pf_sync_fifo.sv
// Synchronous FIFO holding returned index words until the prefetch channel
// accepts them; flush empties it in one cycle.
module pf_sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_push,
    input  logic                    i_pop,
    input  logic                    i_flush,
    input  logic [DATA_W-1:0]       i_data,
    output logic [DATA_W-1:0]       o_head,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [$clog2(DEPTH):0]  o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW:0]       r_wptr;
    logic [AW:0]       r_rptr;
    logic              w_wr;
    logic              w_rd;

    assign o_count = r_wptr - r_rptr;
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_head  = r_mem[r_rptr[AW-1:0]];
    assign w_rd    = i_pop & ~o_empty;
    assign w_wr    = i_push & (~o_full | w_rd);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (i_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + PTR_ONE;
            if (w_rd) r_rptr <= r_rptr + PTR_ONE;
        end
    end

    // Storage carries no reset; the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (w_wr && !i_flush) r_mem[r_wptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/indirect_prefetch_engine.sv
// Indirect stream prefetcher: loads index words B[i] through the L1 load port
// and emits prefetch addresses data_base + (B[i] << shift) with bounded credits.
module indirect_prefetch_engine
    import prefetch_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] cfg_idx_base,
    input  logic [ADDR_W-1:0] cfg_data_base,
    input  logic [2:0]        cfg_shift,
    input  logic [CNT_W-1:0]  cfg_count,
    input  logic [DATA_W-1:0] cfg_limit,
    output logic              ld_req_o,
    output logic [ADDR_W-1:0] ld_addr_o,
    input  logic              ld_gnt_i,
    input  logic              ld_ready_i,
    input  logic [DATA_W-1:0] ld_data_i,
    output logic              pf_valid_o,
    output logic [ADDR_W-1:0] pf_addr_o,
    input  logic              pf_ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  drop_cnt_o,
    output logic [1:0]        state_o
);
    localparam int CR_W = $clog2(DEPTH) + 1;
    localparam logic [CR_W-1:0] CR_DEPTH = CR_W'(DEPTH);

    pf_state_e         r_state;
    pf_state_e         w_state_nxt;
    logic [ADDR_W-1:0] r_idx_base;
    logic [ADDR_W-1:0] r_data_base;
    logic [2:0]        r_shift;
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_limit;
    logic [CNT_W-1:0]  r_issued;
    logic [CNT_W-1:0]  r_drop_cnt;
    logic [CR_W-1:0]   r_credits;
    logic              r_ld_req;
    logic              r_aborted;

    logic              w_start;
    logic              w_abort_act;
    logic              w_discard;
    logic              w_ld_fire;
    logic              w_pf_fire;
    logic              w_resp;
    logic              w_filtered;
    logic              w_rel;
    logic              w_drop;
    logic              w_push;
    logic              w_pop;
    logic              w_ld_req_nxt;
    logic [CNT_W-1:0]  w_issued_nxt;
    logic [CNT_W-1:0]  w_count_nxt;
    logic [CR_W-1:0]   w_cred_dec;
    logic [CR_W-1:0]   w_credits_nxt;
    logic [DATA_W-1:0] w_head;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [CR_W-1:0]   w_fifo_cnt;

    assign w_start     = start & (r_state == ST_IDLE);
    assign w_abort_act = abort & ((r_state == ST_RUN) | (r_state == ST_DRAIN));
    assign w_discard   = r_aborted | w_abort_act;
    assign w_ld_fire   = r_ld_req & ld_gnt_i;
    assign w_pf_fire   = pf_valid_o & pf_ready_i;
    assign w_resp      = ld_ready_i & ((r_state == ST_RUN) | (r_state == ST_DRAIN));
    assign w_filtered  = (r_limit != '0) && (ld_data_i >= r_limit);
    // Every response that does not reach the FIFO gives its credit straight back.
    assign w_rel       = w_resp & (w_discard | w_filtered);
    assign w_drop      = w_resp & ~w_discard & w_filtered;
    assign w_push      = w_resp & ~w_discard & ~w_filtered & (~w_fifo_full | w_pop);
    assign w_pop       = w_pf_fire & ~w_abort_act;

    assign w_issued_nxt = w_start ? '0 : r_issued + CNT_W'(w_ld_fire);
    assign w_count_nxt  = w_start ? cfg_count : r_count;

    // A flush returns the whole FIFO occupancy, which already covers a same-cycle pop.
    always_comb begin
        w_cred_dec    = w_abort_act ? w_fifo_cnt : CR_W'(w_pf_fire);
        w_credits_nxt = r_credits + CR_W'(w_ld_fire) - w_cred_dec - CR_W'(w_rel);
    end

    assign w_ld_req_nxt = (w_state_nxt == ST_RUN) && (w_issued_nxt < w_count_nxt) &&
                          (w_credits_nxt < CR_DEPTH);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_start) w_state_nxt = ST_RUN;
            ST_RUN:   if (w_abort_act || (w_issued_nxt >= r_count)) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (r_credits == '0) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_issued   <= '0;
            r_credits  <= '0;
            r_drop_cnt <= '0;
            r_ld_req   <= 1'b0;
            r_aborted  <= 1'b0;
        end else begin
            r_issued  <= w_issued_nxt;
            r_credits <= w_credits_nxt;
            r_ld_req  <= w_ld_req_nxt;
            if (w_start) begin
                r_drop_cnt <= '0;
                r_aborted  <= 1'b0;
            end else begin
                if (w_drop)      r_drop_cnt <= r_drop_cnt + CNT_W'(1);
                if (w_abort_act) r_aborted  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_start) begin
            r_idx_base  <= cfg_idx_base;
            r_data_base <= cfg_data_base;
            r_shift     <= cfg_shift;
            r_count     <= cfg_count;
            r_limit     <= cfg_limit;
        end
    end

    pf_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_abort_act),
        .i_data  (ld_data_i),
        .o_head  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_cnt)
    );

    // Address outputs are forced to zero whenever their valid is low.
    assign ld_req_o   = r_ld_req;
    assign ld_addr_o  = r_ld_req ? (r_idx_base + (ADDR_W'(r_issued) << IDX_SHIFT)) : '0;
    assign pf_valid_o = ~w_fifo_empty;
    assign pf_addr_o  = w_fifo_empty ? '0 : (r_data_base + (ADDR_W'(w_head) << r_shift));
    assign busy_o     = (r_state != ST_IDLE);
    assign done_o     = (r_state == ST_DONE);
    assign drop_cnt_o = r_drop_cnt;
    assign state_o    = r_state;

endmodule

// File: tb/tb_indirect_prefetch_engine.sv
// Directed bench for indirect_prefetch_engine with a small in-order load
// responder and logs of granted loads and accepted prefetches.
module tb_indirect_prefetch_engine;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] cfg_idx_base;
    logic [ADDR_W-1:0] cfg_data_base;
    logic [2:0]        cfg_shift;
    logic [CNT_W-1:0]  cfg_count;
    logic [DATA_W-1:0] cfg_limit;
    logic              ld_req_o;
    logic [ADDR_W-1:0] ld_addr_o;
    logic              ld_gnt_i;
    logic              ld_ready_i;
    logic [DATA_W-1:0] ld_data_i;
    logic              pf_valid_o;
    logic [ADDR_W-1:0] pf_addr_o;
    logic              pf_ready_i;
    logic              busy_o;
    logic              done_o;
    logic [CNT_W-1:0]  drop_cnt_o;
    logic [1:0]        state_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lat = 1;
    int done_cnt = 0;
    int done_cyc = -1;
    int rsp_cnt = 0;
    int max_cred = 0;
    logic gnt_en = 1'b1;
    logic pfr_en = 1'b1;
    logic [DATA_W-1:0] b_mem [16];
    logic [ADDR_W-1:0] ld_log [$];
    logic [ADDR_W-1:0] pf_log [$];
    int                rsp_due [$];
    logic [DATA_W-1:0] rsp_dat [$];

    always #5 clk = ~clk;

    indirect_prefetch_engine #(
        .ADDR_W (ADDR_W), .DATA_W (DATA_W), .DEPTH (DEPTH), .CNT_W (CNT_W)
    ) dut (
        .clk (clk), .reset (reset), .start (start), .abort (abort),
        .cfg_idx_base (cfg_idx_base), .cfg_data_base (cfg_data_base),
        .cfg_shift (cfg_shift), .cfg_count (cfg_count), .cfg_limit (cfg_limit),
        .ld_req_o (ld_req_o), .ld_addr_o (ld_addr_o), .ld_gnt_i (ld_gnt_i),
        .ld_ready_i (ld_ready_i), .ld_data_i (ld_data_i),
        .pf_valid_o (pf_valid_o), .pf_addr_o (pf_addr_o), .pf_ready_i (pf_ready_i),
        .busy_o (busy_o), .done_o (done_o), .drop_cnt_o (drop_cnt_o), .state_o (state_o)
    );

    // One cycle: drive inputs at the falling edge, log handshakes the next rising edge takes.
    task automatic tick(input logic st, input logic ab);
        logic [ADDR_W-1:0] off;
        @(negedge clk);
        start = st;
        abort = ab;
        ld_gnt_i = gnt_en;
        pf_ready_i = pfr_en;
        ld_ready_i = 1'b0;
        ld_data_i = '0;
        if (rsp_due.size() > 0 && rsp_due[0] == cyc) begin
            ld_ready_i = 1'b1;
            ld_data_i = rsp_dat.pop_front();
            void'(rsp_due.pop_front());
            rsp_cnt++;
        end
        if (ld_req_o && ld_gnt_i) begin
            ld_log.push_back(ld_addr_o);
            off = (ld_addr_o - cfg_idx_base) >> 2;
            rsp_due.push_back(cyc + lat);
            rsp_dat.push_back(b_mem[off[3:0]]);
        end
        if (pf_valid_o && pf_ready_i) pf_log.push_back(pf_addr_o);
        if (int'(ld_log.size()) - int'(pf_log.size()) > max_cred)
            max_cred = int'(ld_log.size()) - int'(pf_log.size());
        if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
        end
        cyc++;
    endtask

    task automatic clear_logs();
        ld_log.delete();
        pf_log.delete();
        rsp_due.delete();
        rsp_dat.delete();
        done_cnt = 0;
        done_cyc = -1;
        rsp_cnt = 0;
        max_cred = 0;
    endtask

    task automatic basic_cfg(input logic [CNT_W-1:0] cnt, input logic [DATA_W-1:0] lim);
        cfg_idx_base = 32'h1000;
        cfg_data_base = 32'h8000;
        cfg_shift = 3'd2;
        cfg_count = cnt;
        cfg_limit = lim;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        ld_gnt_i = 1'b0; ld_ready_i = 1'b0; ld_data_i = '0; pf_ready_i = 1'b0;
        basic_cfg(16'd0, '0);
        repeat (3) @(negedge clk);
        checks++;
        if ({ld_req_o, ld_addr_o, pf_valid_o, pf_addr_o, busy_o, done_o, drop_cnt_o, state_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got req=%0b ldaddr=%0h pfv=%0b pfaddr=%0h busy=%0b done=%0b drop=%0d state=%0d, expected all 0",
                     ld_req_o, ld_addr_o, pf_valid_o, pf_addr_o, busy_o, done_o, drop_cnt_o, state_o);
        end
        reset = 1'b0;
        repeat (2) tick(1'b0, 1'b0);
        checks++;
        if ({busy_o, state_o} !== 3'b000) begin
            errors++;
            $display("FAIL reset_idle: got busy=%0b state=%0d, expected busy=0 state=0", busy_o, state_o);
        end
    endtask

    task automatic run_basic(input string nm);
        logic [ADDR_W-1:0] exp_ld [4];
        logic [ADDR_W-1:0] exp_pf [4];
        logic [ADDR_W-1:0] got;
        exp_ld = '{32'h1000, 32'h1004, 32'h1008, 32'h100C};
        exp_pf = '{32'h800C, 32'h8000, 32'h801C, 32'h8004};
        clear_logs();
        basic_cfg(16'd4, '0);
        b_mem[0] = 32'd3; b_mem[1] = 32'd0; b_mem[2] = 32'd7; b_mem[3] = 32'd1;
        gnt_en = 1'b1; pfr_en = 1'b1; lat = 1;
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        checks++;
        if ({state_o, ld_req_o, ld_addr_o} !== {2'd1, 1'b1, 32'h1000}) begin
            errors++;
            $display("FAIL %s_first_req: got state=%0d req=%0b addr=%0h, expected state=1 req=1 addr=1000",
                     nm, state_o, ld_req_o, ld_addr_o);
        end
        repeat (15) tick(1'b0, 1'b0);
        checks++;
        if (ld_log.size() != 4 || pf_log.size() != 4) begin
            errors++;
            $display("FAIL %s_counts: got loads=%0d prefetches=%0d, expected 4 and 4", nm, ld_log.size(), pf_log.size());
        end
        for (int i = 0; i < 4; i++) begin
            got = (i < int'(ld_log.size())) ? ld_log[i] : '1;
            checks++;
            if (got !== exp_ld[i]) begin
                errors++;
                $display("FAIL %s_ld_addr[%0d]: got %0h, expected %0h", nm, i, got, exp_ld[i]);
            end
            got = (i < int'(pf_log.size())) ? pf_log[i] : '1;
            checks++;
            if (got !== exp_pf[i]) begin
                errors++;
                $display("FAIL %s_pf_addr[%0d]: got %0h, expected %0h", nm, i, got, exp_pf[i]);
            end
        end
        checks++;
        if (done_cnt != 1 || max_cred > DEPTH || busy_o !== 1'b0 || state_o !== 2'd0) begin
            errors++;
            $display("FAIL %s_end: got done_pulses=%0d max_credits=%0d busy=%0b state=%0d, expected 1, <=4, 0, 0",
                     nm, done_cnt, max_cred, busy_o, state_o);
        end
    endtask

    task automatic test_zero_count();
        int s;
        int req_seen;
        clear_logs();
        basic_cfg(16'd0, '0);
        req_seen = 0;
        s = cyc;
        tick(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0);
            if (ld_req_o) req_seen++;
        end
        checks++;
        if (state_o !== 2'd3) begin
            errors++;
            $display("FAIL zero_state_done: got %0d, expected 3", state_o);
        end
        repeat (3) begin
            tick(1'b0, 1'b0);
            if (ld_req_o) req_seen++;
        end
        checks++;
        if (done_cyc != s + 3 || done_cnt != 1) begin
            errors++;
            $display("FAIL zero_done_timing: got offset=%0d pulses=%0d, expected offset=3 pulses=1", done_cyc - s, done_cnt);
        end
        checks++;
        if (req_seen != 0 || ld_log.size() != 0 || state_o !== 2'd0) begin
            errors++;
            $display("FAIL zero_no_req: got req_cycles=%0d loads=%0d state=%0d, expected 0 0 0", req_seen, ld_log.size(), state_o);
        end
    endtask

    task automatic test_backpressure();
        logic [ADDR_W-1:0] exp_pf [8];
        logic [ADDR_W-1:0] got;
        int unstable;
        int req_hi;
        exp_pf = '{32'h800C, 32'h8000, 32'h801C, 32'h8004, 32'h8028, 32'h802C, 32'h8030, 32'h8034};
        clear_logs();
        basic_cfg(16'd8, '0);
        b_mem[0] = 32'd3;  b_mem[1] = 32'd0;  b_mem[2] = 32'd7;  b_mem[3] = 32'd1;
        b_mem[4] = 32'd10; b_mem[5] = 32'd11; b_mem[6] = 32'd12; b_mem[7] = 32'd13;
        gnt_en = 1'b1; pfr_en = 1'b0; lat = 1;
        unstable = 0; req_hi = 0;
        tick(1'b1, 1'b0);
        repeat (6) tick(1'b0, 1'b0);
        // A second start with different settings arrives while busy and must be ignored.
        cfg_data_base = 32'hF000;
        cfg_count = 16'd1;
        for (int i = 0; i < 8; i++) begin
            tick(i == 3, 1'b0);
            if (!pf_valid_o || pf_addr_o !== 32'h800C) unstable++;
            if (ld_req_o) req_hi++;
        end
        checks++;
        if (ld_log.size() != 4 || req_hi != 0) begin
            errors++;
            $display("FAIL bp_grant_limit: got grants=%0d req_cycles=%0d, expected 4 and 0", ld_log.size(), req_hi);
        end
        checks++;
        if (unstable != 0 || pf_log.size() != 0) begin
            errors++;
            $display("FAIL bp_pf_stable: got unstable_cycles=%0d accepted=%0d, expected 0 and 0", unstable, pf_log.size());
        end
        pfr_en = 1'b1;
        repeat (30) tick(1'b0, 1'b0);
        checks++;
        if (ld_log.size() != 8 || pf_log.size() != 8 || done_cnt != 1 || max_cred > DEPTH) begin
            errors++;
            $display("FAIL bp_resume: got loads=%0d prefetches=%0d done=%0d max_credits=%0d, expected 8 8 1 <=4",
                     ld_log.size(), pf_log.size(), done_cnt, max_cred);
        end
        for (int i = 0; i < 8; i++) begin
            got = (i < int'(pf_log.size())) ? pf_log[i] : '1;
            checks++;
            if (got !== exp_pf[i]) begin
                errors++;
                $display("FAIL bp_pf_addr[%0d]: got %0h, expected %0h", i, got, exp_pf[i]);
            end
        end
    endtask

    task automatic test_filter();
        clear_logs();
        basic_cfg(16'd4, 32'd5);
        b_mem[0] = 32'd2; b_mem[1] = 32'd9; b_mem[2] = 32'd5; b_mem[3] = 32'd4;
        gnt_en = 1'b1; pfr_en = 1'b1; lat = 1;
        tick(1'b1, 1'b0);
        repeat (16) tick(1'b0, 1'b0);
        checks++;
        if (pf_log.size() != 2 || (pf_log.size() == 2 && (pf_log[0] !== 32'h8008 || pf_log[1] !== 32'h8010))) begin
            errors++;
            $display("FAIL filter_pf: got count=%0d first=%0h second=%0h, expected 2 8008 8010",
                     pf_log.size(), (pf_log.size() > 0) ? pf_log[0] : 32'hFFFF_FFFF,
                     (pf_log.size() > 1) ? pf_log[1] : 32'hFFFF_FFFF);
        end
        checks++;
        if (drop_cnt_o !== 16'd2 || done_cnt != 1) begin
            errors++;
            $display("FAIL filter_drop: got drop=%0d done=%0d, expected 2 and 1", drop_cnt_o, done_cnt);
        end
        repeat (4) tick(1'b0, 1'b0);
        checks++;
        if (drop_cnt_o !== 16'd2) begin
            errors++;
            $display("FAIL filter_drop_hold: got %0d, expected 2", drop_cnt_o);
        end
    endtask

    task automatic test_abort();
        int ab_cyc;
        int pfv_after;
        int req_after;
        clear_logs();
        basic_cfg(16'd16, '0);
        for (int i = 0; i < 16; i++) b_mem[i] = DATA_W'(i + 1);
        gnt_en = 1'b1; pfr_en = 1'b0; lat = 2;
        pfv_after = 0; req_after = 0;
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        checks++;
        if (drop_cnt_o !== 16'd0) begin
            errors++;
            $display("FAIL abort_drop_clear: got %0d, expected 0", drop_cnt_o);
        end
        for (int i = 0; i < 10 && ld_log.size() < 3; i++) tick(1'b0, 1'b0);
        gnt_en = 1'b0;
        ab_cyc = cyc;
        tick(1'b0, 1'b1);
        checks++;
        if ({ld_req_o, pf_valid_o} !== 2'b11 || ld_log.size() != 3) begin
            errors++;
            $display("FAIL abort_pre: got req=%0b pf_valid=%0b grants=%0d, expected 1 1 3", ld_req_o, pf_valid_o, ld_log.size());
        end
        gnt_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 1'b0);
            if (pf_valid_o) pfv_after++;
            if (ld_req_o) req_after++;
            if (done_cnt > 0) break;
        end
        checks++;
        if (req_after != 0 || pfv_after != 0 || ld_log.size() != 3 || pf_log.size() != 0) begin
            errors++;
            $display("FAIL abort_quiet: got req_cycles=%0d pf_valid_cycles=%0d grants=%0d prefetches=%0d, expected 0 0 3 0",
                     req_after, pfv_after, ld_log.size(), pf_log.size());
        end
        checks++;
        if (done_cnt != 1 || done_cyc != ab_cyc + 3 || rsp_cnt != 3) begin
            errors++;
            $display("FAIL abort_done: got pulses=%0d offset=%0d responses=%0d, expected 1 3 3",
                     done_cnt, done_cyc - ab_cyc, rsp_cnt);
        end
        tick(1'b0, 1'b0);
        checks++;
        if ({busy_o, state_o} !== 3'b000) begin
            errors++;
            $display("FAIL abort_idle: got busy=%0b state=%0d, expected 0 0", busy_o, state_o);
        end
    endtask

    task automatic test_reset_mid_run();
        clear_logs();
        basic_cfg(16'd4, '0);
        b_mem[0] = 32'd3; b_mem[1] = 32'd0; b_mem[2] = 32'd7; b_mem[3] = 32'd1;
        gnt_en = 1'b1; pfr_en = 1'b1; lat = 3;
        tick(1'b1, 1'b0);
        repeat (2) tick(1'b0, 1'b0);
        gnt_en = 1'b0;
        tick(1'b0, 1'b0);
        checks++;
        if ({busy_o, ld_req_o, state_o} !== 4'b1101 || ld_log.size() != 2) begin
            errors++;
            $display("FAIL midrst_pre: got busy=%0b req=%0b state=%0d grants=%0d, expected 1 1 1 2",
                     busy_o, ld_req_o, state_o, ld_log.size());
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({ld_req_o, ld_addr_o, pf_valid_o, pf_addr_o, busy_o, done_o, drop_cnt_o, state_o} !== '0) begin
            errors++;
            $display("FAIL midrst_async: got req=%0b ldaddr=%0h pfv=%0b busy=%0b state=%0d, expected all 0",
                     ld_req_o, ld_addr_o, pf_valid_o, busy_o, state_o);
        end
        @(negedge clk);
        reset = 1'b0;
        run_basic("rerun");
    endtask

    initial begin
        test_reset();
        run_basic("basic");
        test_zero_count();
        test_backpressure();
        test_filter();
        test_abort();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
